// File: rtl/hybrid_drive_scheduler.sv
// Hybrid drivetrain scheduler: picks electric or gas drive each cycle, tracks battery and fuel
// levels as saturating counters, and holds each motor mode for a minimum dwell time.
module hybrid_drive_scheduler #(
  parameter int W        = 6,
  parameter int BAT_MAX  = 20,
  parameter int TANK_MAX = 15,
  parameter int BAT_LOW  = 4,
  parameter int DWELL    = 3
) (
  input  logic         CLK,
  input  logic         REINICIO,
  input  logic         ARRANQUE,
  input  logic         PARADA,
  input  logic         MODO,
  input  logic         CARGA,
  input  logic         RECARGA_TANQUE,
  output logic         MOTOR1,
  output logic         MOTOR2,
  output logic [W-1:0] BATERIA,
  output logic [W-1:0] TANQUE,
  output logic [1:0]   ESTADO
);

  localparam int DW = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

  localparam logic [W-1:0]  BAT_MAX_V  = W'(BAT_MAX);
  localparam logic [W-1:0]  TANK_MAX_V = W'(TANK_MAX);
  localparam logic [W-1:0]  BAT_LOW_V  = W'(BAT_LOW);
  localparam logic [W-1:0]  LVL_ONE    = W'(1);
  localparam logic [W-1:0]  LVL_ZERO   = '0;
  localparam logic [DW-1:0] DWELL_V    = DW'(DWELL);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  typedef enum logic [1:0] {
    S_REPOSO    = 2'd0,
    S_ELECTRICO = 2'd1,
    S_GAS       = 2'd2,
    S_AGOTADO   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   bat_q, bat_d;
  logic [W-1:0]   tank_q, tank_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           dwell_ok;

  assign dwell_ok = (dwell_q == DWELL_V);

  always_ff @(posedge CLK or posedge REINICIO) begin
    if (REINICIO) begin
      state_q <= S_REPOSO;
      bat_q   <= BAT_MAX_V;
      tank_q  <= TANK_MAX_V;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      bat_q   <= bat_d;
      tank_q  <= tank_d;
      dwell_q <= dwell_d;
    end
  end

  // All decisions look at the registered levels; the level updates land on the same edge.
  always_comb begin
    state_d = state_q;
    bat_d   = bat_q;
    tank_d  = tank_q;
    case (state_q)
      S_REPOSO: begin
        if (CARGA && (bat_q < BAT_MAX_V)) bat_d = bat_q + LVL_ONE;
        if (RECARGA_TANQUE) tank_d = TANK_MAX_V;
        if (!PARADA && ARRANQUE) begin
          if ((bat_q == LVL_ZERO) && (tank_q == LVL_ZERO)) state_d = S_AGOTADO;
          else if (!MODO && (bat_q > BAT_LOW_V))           state_d = S_ELECTRICO;
          else if (tank_q != LVL_ZERO)                     state_d = S_GAS;
          else                                             state_d = S_ELECTRICO;
        end
      end
      S_ELECTRICO: begin
        if (bat_q != LVL_ZERO) bat_d = bat_q - LVL_ONE;
        if (PARADA) begin
          state_d = S_REPOSO;
        end else if (bat_q == LVL_ZERO) begin
          state_d = (tank_q != LVL_ZERO) ? S_GAS : S_AGOTADO;
        end else if (((bat_q <= BAT_LOW_V) || MODO) && dwell_ok && (tank_q != LVL_ZERO)) begin
          state_d = S_GAS;
        end
      end
      S_GAS: begin
        if (tank_q != LVL_ZERO) tank_d = tank_q - LVL_ONE;
        if (bat_q < BAT_MAX_V)  bat_d  = bat_q + LVL_ONE;
        if (PARADA) begin
          state_d = S_REPOSO;
        end else if (tank_q == LVL_ZERO) begin
          state_d = (bat_q != LVL_ZERO) ? S_ELECTRICO : S_AGOTADO;
        end else if (!MODO && (bat_q == BAT_MAX_V) && dwell_ok) begin
          state_d = S_ELECTRICO;
        end
      end
      S_AGOTADO: begin
        if (RECARGA_TANQUE) tank_d = TANK_MAX_V;
        if (CARGA && (bat_q < BAT_MAX_V)) bat_d = bat_q + LVL_ONE;
        if (RECARGA_TANQUE || CARGA) state_d = S_REPOSO;
      end
      default: begin
        state_d = S_REPOSO;
      end
    endcase
  end

  // Dwell restarts on any state change and only counts while a motor is driving.
  always_comb begin
    dwell_d = dwell_q;
    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (((state_q == S_ELECTRICO) || (state_q == S_GAS)) && !dwell_ok) begin
      dwell_d = dwell_q + DWELL_ONE;
    end
  end

  always_comb begin
    MOTOR1  = (state_q == S_ELECTRICO);
    MOTOR2  = (state_q == S_GAS);
    BATERIA = bat_q;
    TANQUE  = tank_q;
    ESTADO  = state_q;
  end

endmodule

// File: tb/tb_hybrid_drive_scheduler.sv
// Scoreboard bench for hybrid_drive_scheduler: a behavioural model predicts each cycle's outputs,
// and a monitor compares the DUT against the queued predictions after every rising edge.
module tb_hybrid_drive_scheduler;

  localparam int W        = 6;
  localparam int BAT_MAX  = 20;
  localparam int TANK_MAX = 15;
  localparam int BAT_LOW  = 4;
  localparam int DWELL    = 3;

  localparam int REPOSO = 0, ELECTRICO = 1, GAS = 2, AGOTADO = 3;

  logic         CLK;
  logic         REINICIO;
  logic         ARRANQUE, PARADA, MODO, CARGA, RECARGA_TANQUE;
  logic         MOTOR1, MOTOR2;
  logic [W-1:0] BATERIA, TANQUE;
  logic [1:0]   ESTADO;

  hybrid_drive_scheduler #(
    .W(W), .BAT_MAX(BAT_MAX), .TANK_MAX(TANK_MAX), .BAT_LOW(BAT_LOW), .DWELL(DWELL)
  ) dut (
    .CLK(CLK), .REINICIO(REINICIO), .ARRANQUE(ARRANQUE), .PARADA(PARADA), .MODO(MODO),
    .CARGA(CARGA), .RECARGA_TANQUE(RECARGA_TANQUE), .MOTOR1(MOTOR1), .MOTOR2(MOTOR2),
    .BATERIA(BATERIA), .TANQUE(TANQUE), .ESTADO(ESTADO)
  );

  typedef struct {
    int st;
    int bat;
    int tank;
  } expect_t;

  expect_t expQ[$];
  int testsRun = 0;
  int failures = 0;

  // Reference model: plain integers stepped by the behavioural rules.
  int mState, mBat, mTank, mDwell;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkValue(input string name, input int actual, input int required);
    testsRun++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checkValue("ESTADO", int'(ESTADO), e.st);
    checkValue("MOTOR1", int'(MOTOR1), (e.st == ELECTRICO) ? 1 : 0);
    checkValue("MOTOR2", int'(MOTOR2), (e.st == GAS) ? 1 : 0);
    checkValue("BATERIA", int'(BATERIA), e.bat);
    checkValue("TANQUE", int'(TANQUE), e.tank);
  endtask

  function automatic expect_t resetExpect();
    expect_t e;
    e.st = REPOSO; e.bat = BAT_MAX; e.tank = TANK_MAX;
    return e;
  endfunction

  task automatic modelReset();
    mState = REPOSO; mBat = BAT_MAX; mTank = TANK_MAX; mDwell = 0;
  endtask

  task automatic modelStep(input bit arr, input bit par, input bit modo,
                           input bit carga, input bit rec);
    int nState = mState;
    int nBat   = mBat;
    int nTank  = mTank;
    bit dwellOk = (mDwell == DWELL);
    if (mState == REPOSO) begin
      if (carga) nBat = (mBat + 1 > BAT_MAX) ? BAT_MAX : mBat + 1;
      if (rec) nTank = TANK_MAX;
      if (!par && arr) begin
        if (mBat == 0 && mTank == 0) nState = AGOTADO;
        else if (!modo && mBat > BAT_LOW) nState = ELECTRICO;
        else if (mTank > 0) nState = GAS;
        else nState = ELECTRICO;
      end
    end else if (mState == ELECTRICO) begin
      nBat = (mBat > 0) ? mBat - 1 : 0;
      if (par) nState = REPOSO;
      else if (mBat == 0) nState = (mTank > 0) ? GAS : AGOTADO;
      else if ((mBat <= BAT_LOW || modo) && dwellOk && mTank > 0) nState = GAS;
    end else if (mState == GAS) begin
      nTank = (mTank > 0) ? mTank - 1 : 0;
      nBat  = (mBat < BAT_MAX) ? mBat + 1 : BAT_MAX;
      if (par) nState = REPOSO;
      else if (mTank == 0) nState = (mBat > 0) ? ELECTRICO : AGOTADO;
      else if (!modo && mBat == BAT_MAX && dwellOk) nState = ELECTRICO;
    end else begin
      if (rec) nTank = TANK_MAX;
      if (carga) nBat = (mBat + 1 > BAT_MAX) ? BAT_MAX : mBat + 1;
      if (rec || carga) nState = REPOSO;
    end
    if (nState != mState) mDwell = 0;
    else if (mState == ELECTRICO || mState == GAS) mDwell = (mDwell < DWELL) ? mDwell + 1 : DWELL;
    mState = nState; mBat = nBat; mTank = nTank;
  endtask

  // Called at a falling edge: drive inputs, predict the result of the coming rising edge.
  task automatic applyStimulus(input bit arr, input bit par, input bit modo,
                               input bit carga, input bit rec);
    expect_t e;
    ARRANQUE = arr; PARADA = par; MODO = modo; CARGA = carga; RECARGA_TANQUE = rec;
    modelStep(arr, par, modo, carga, rec);
    e.st = mState; e.bat = mBat; e.tank = mTank;
    expQ.push_back(e);
    @(negedge CLK);
  endtask

  // Asynchronous reset mid-cycle: outputs must reset before any clock edge.
  task automatic asyncReset();
    #1 REINICIO = 1'b1;
    #1 checkOutput(resetExpect());
    modelReset();
    @(negedge CLK);
    REINICIO = 1'b0;
  endtask

  always @(posedge CLK) begin
    #2;
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    bit modoR;
    REINICIO = 1'b1;
    ARRANQUE = 1'b0; PARADA = 1'b0; MODO = 1'b0; CARGA = 1'b0; RECARGA_TANQUE = 1'b0;
    #2 checkOutput(resetExpect());
    modelReset();
    @(negedge CLK);
    REINICIO = 1'b0;

    // Long electric-preferred run: electric -> gas -> forced electric -> exhausted.
    for (int i = 0; i < 80; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gas start with a full battery, then ask for electric: must wait out the dwell.
    asyncReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Randomized phase with sticky mode preference and occasional resets.
    modoR = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) modoR = ~modoR;
      applyStimulus(1'($urandom_range(1)), ($urandom_range(19) == 0), modoR,
                    ($urandom_range(2) == 0), ($urandom_range(9) == 0));
      if ($urandom_range(399) == 0) asyncReset();
    end

    @(negedge CLK);
    checkValue("scoreboard_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
